// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared types and sizing helpers for seq_adder_n
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        return (ndig(width, digit) > 1) ? $clog2(ndig(width, digit)) : 1;
    endfunction

endpackage

// File: rtl/seq_adder_digit_adder.sv
// rtl/seq_adder_digit_adder.sv - combinational DIGIT-bit ripple adder
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + (DIGIT+1)'(ci);

endmodule

// File: rtl/seq_adder_n.sv
// rtl/seq_adder_n.sv - multi-cycle add/subtract, DIGIT bits per clock, LSB first
module seq_adder_n
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("seq_adder_n: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
    logic [CW-1:0]    cnt;
    logic             carry, a_msb, b_msb;
    logic [DIGIT-1:0] dsum;
    logic             dco;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a  (a_q[DIGIT-1:0]),
        .b  (b_q[DIGIT-1:0]),
        .ci (carry),
        .s  (dsum),
        .co (dco)
    );

    // New digit enters at the top so the LSB digit ends at bit 0 after NDIG shifts.
    assign res_next = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    // Subtract as A + ~B + ~cin.
                    a_q   <= A;
                    b_q   <= B ^ {WIDTH{sub}};
                    carry <= cin ^ sub;
                    cnt   <= '0;
                    a_msb <= A[WIDTH-1];
                    b_msb <= B[WIDTH-1] ^ sub;
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    res_q <= res_next;
                    carry <= dco;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum  <= res_next;
                        cout <= dco;
                        ovf  <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder_n.sv
// tb/tb_seq_adder_n.sv - directed and randomized checks of seq_adder_n
module tb_seq_adder_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_m = 1'b0;
    logic        start_s = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;

    logic        busy_m, done_m, cout_m, ovf_m;
    logic [7:0]  sum_m;
    logic        busy_1, done_1, cout_1, ovf_1;
    logic [7:0]  sum_1;
    logic        busy_2, done_2, cout_2, ovf_2;
    logic [31:0] sum_2;
    logic        busy_3, done_3, cout_3, ovf_3;
    logic [15:0] sum_3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_adder_n #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start_m), .A(a[7:0]), .B(b[7:0]), .cin(cin), .sub(sub),
        .busy(busy_m), .done(done_m), .sum(sum_m), .cout(cout_m), .ovf(ovf_m));

    seq_adder_n #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst(rst), .start(start_s), .A(a[7:0]), .B(b[7:0]), .cin(cin), .sub(sub),
        .busy(busy_1), .done(done_1), .sum(sum_1), .cout(cout_1), .ovf(ovf_1));

    seq_adder_n #(.WIDTH(32), .DIGIT(4)) u_w32d4 (
        .clk(clk), .rst(rst), .start(start_s), .A(a), .B(b), .cin(cin), .sub(sub),
        .busy(busy_2), .done(done_2), .sum(sum_2), .cout(cout_2), .ovf(ovf_2));

    seq_adder_n #(.WIDTH(16), .DIGIT(1)) u_w16d1 (
        .clk(clk), .rst(rst), .start(start_s), .A(a[15:0]), .B(b[15:0]), .cin(cin), .sub(sub),
        .busy(busy_3), .done(done_3), .sum(sum_3), .cout(cout_3), .ovf(ovf_3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed-integer reference: {ovf, cout, sum} for a w-bit operation.
    function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        longint m, ux, uy, sx, sy, t, r;
        logic co, ov;
        m  = (longint'(1) << w) - 1;
        ux = longint'(x) & m;
        uy = longint'(y) & m;
        sx = ux[w-1] ? ux - (longint'(1) << w) : ux;
        sy = uy[w-1] ? uy - (longint'(1) << w) : uy;
        if (s) begin
            t  = sx - sy - longint'(c);
            co = (ux >= uy + longint'(c));
        end else begin
            t  = sx + sy + longint'(c);
            co = ((ux + uy + longint'(c)) >> w) != 0;
        end
        ov = (t > (longint'(1) << (w - 1)) - 1) || (t < -(longint'(1) << (w - 1)));
        r  = t & m;
        return {ov, co, r[31:0]};
    endfunction

    task automatic go_m(input logic [7:0] aa, input logic [7:0] bb, input logic c, input logic s);
        a = {24'h0, aa};
        b = {24'h0, bb};
        cin = c;
        sub = s;
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
    endtask

    task automatic wait_m(output int n, output int bc);
        n = 0;
        bc = 0;
        while (!done_m && n < 40) begin
            if (busy_m) bc++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_m(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                         input logic c, input logic s,
                         input logic [7:0] es, input logic ec, input logic eo);
        int n, bc;
        go_m(aa, bb, c, s);
        wait_m(n, bc);
        chk({tag, "_lat"}, 64'(n), 64'd4);
        chk({tag, "_busy"}, 64'(bc), 64'd4);
        chk({tag, "_sum"}, 64'(sum_m), 64'(es));
        chk({tag, "_cout"}, 64'(cout_m), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf_m), 64'(eo));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'({done_m, busy_m}), 64'd0);
    endtask

    initial begin
        int n, bc, lat1, lat2, lat3;
        logic seen;
        logic [33:0] e1, e2, e3;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_m), 64'd0);
        chk("rst_done", 64'(done_m), 64'd0);
        chk("rst_sum",  64'(sum_m), 64'd0);
        chk("rst_flags", 64'({cout_m, ovf_m}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_m("add_basic", 8'h06, 8'h0B, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
        run_m("add_cin",   8'hCA, 8'hF1, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0);
        run_m("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_m("sub_neg",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_m("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start re-asserted during RUN with different operands must be ignored
        go_m(8'h06, 8'h0B, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 32'hFF;
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        wait_m(n, bc);
        chk("rerun_lat", 64'(n + 2), 64'd4);
        chk("rerun_sum", 64'(sum_m), 64'h11);
        @(posedge clk); #1;
        chk("rerun_idle", 64'({done_m, busy_m}), 64'd0);

        // reset sampled on the 2nd RUN cycle aborts the operation
        go_m(8'h7F, 8'h01, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy_m), 64'd0);
        chk("abort_done", 64'(done_m), 64'd0);
        chk("abort_sum",  64'(sum_m), 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_m || busy_m) seen = 1'b1;
        end
        chk("abort_quiet", 64'(seen), 64'd0);
        run_m("after_abort", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);

        // start and rst together: rst wins
        a = 32'h01; b = 32'h01;
        start_m = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        rst = 1'b0;
        chk("rst_wins", 64'(busy_m), 64'd0);

        // parameter sweep against the signed-integer model
        for (int i = 0; i < 1000; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            if (i < 4) begin
                a = (i[0]) ? 32'hFFFF_FFFF : 32'h8000_0000;
                b = (i[1]) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            end
            e1 = model(8, a, b, cin, sub);
            e2 = model(32, a, b, cin, sub);
            e3 = model(16, a, b, cin, sub);
            start_s = 1'b1;
            @(posedge clk); #1;
            start_s = 1'b0;
            lat1 = -1; lat2 = -1; lat3 = -1;
            for (int k = 1; k <= 17; k++) begin
                @(posedge clk); #1;
                if (done_1 && lat1 < 0) lat1 = k;
                if (done_2 && lat2 < 0) lat2 = k;
                if (done_3 && lat3 < 0) lat3 = k;
            end
            chk("w8d8_lat",  64'(lat1), 64'd1);
            chk("w8d8_res",  64'({ovf_1, cout_1, sum_1}), 64'({e1[33:32], e1[7:0]}));
            chk("w32d4_lat", 64'(lat2), 64'd8);
            chk("w32d4_res", 64'({ovf_2, cout_2, sum_2}), 64'(e2));
            chk("w16d1_lat", 64'(lat3), 64'd16);
            chk("w16d1_res", 64'({ovf_3, cout_3, sum_3}), 64'({e3[33:32], e3[15:0]}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
